// File: rtl/fp_pkg.sv
// Shared types and constants for the floating-point datapath.
// Canonical encodings are returned as 64-bit words so callers can slice to their own widths.
package fp_pkg;

    localparam int unsigned MW   = 23;
    localparam int unsigned EW   = 8;
    localparam int unsigned BIAS = 127;

    typedef enum logic [1:0] {
        S_IDLE,
        S_NORM,
        S_ROUND,
        S_PACK
    } fsm_state_t;

    typedef struct packed {
        logic ovf;
        logic unf;
        logic inx;
    } fp_flags_t;

    // Exponent and fraction bits of the quiet NaN (sign not included).
    function automatic logic [63:0] fp_qnan(input int unsigned ew, input int unsigned mw);
        logic [63:0] ones;
        ones = (64'd1 << ew) - 64'd1;
        return (ones << mw) | (64'd1 << (mw - 1));
    endfunction

    // Exponent and fraction bits of infinity (sign not included).
    function automatic logic [63:0] fp_inf(input int unsigned ew, input int unsigned mw);
        logic [63:0] ones;
        ones = (64'd1 << ew) - 64'd1;
        return ones << mw;
    endfunction

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even on a truncated fraction with guard and sticky bits.
// A carry out means the fraction wrapped to zero and the exponent must step up.
module fp_round_rne #(
    parameter int unsigned W = 23
) (
    input  logic [W-1:0] frac,
    input  logic         guard,
    input  logic         sticky,
    output logic [W-1:0] frac_rnd,
    output logic         carry,
    output logic         inexact
);

    logic         round_up;
    logic [W:0]   sum;

    always_comb begin
        round_up = guard & (sticky | frac[0]);
        sum      = {1'b0, frac} + {{W{1'b0}}, round_up};
        frac_rnd = sum[W-1:0];
        carry    = sum[W];
        inexact  = guard | sticky;
    end

endmodule

// File: rtl/fp_mul_norm_round.sv
// Normalise, round (RNE) and pack stage of the FP multiplier.
// Result and flags are registered on the ROUND->PACK edge and held until the next operation.
module fp_mul_norm_round #(
    parameter int unsigned MW = fp_pkg::MW,
    parameter int unsigned EW = fp_pkg::EW
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_sign,
    input  logic signed [EW+1:0] in_exp_sum,
    input  logic [2*(MW+1)-1:0]  in_prod,
    input  logic                 in_zero,
    input  logic                 in_inf,
    input  logic                 in_nan,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EW+MW:0]       out_result,
    output logic                 out_ovf,
    output logic                 out_unf,
    output logic                 out_inx
);

    import fp_pkg::*;

    localparam int unsigned PW = 2 * (MW + 1);
    localparam int unsigned XW = EW + 2;
    localparam logic [63:0] QNAN_W = fp_qnan(EW, MW);
    localparam logic [63:0] INF_W  = fp_inf(EW, MW);
    localparam logic signed [XW-1:0] EXP_ONE  = 1;
    localparam logic signed [XW-1:0] EXP_ZERO = 0;
    localparam logic signed [XW-1:0] EXP_MAX  = $signed({2'b00, {EW{1'b1}}});

    fsm_state_t state, state_nx;
    logic       load_in, do_norm, do_round;

    logic                 r_sign, r_zero, r_inf, r_nan;
    logic signed [XW-1:0] r_exp;
    logic [PW-1:0]        r_prod;
    logic [MW-1:0]        r_frac;
    logic                 r_guard, r_sticky;
    fp_flags_t            flags_q;

    logic [MW-1:0]        n_frac;
    logic                 n_guard, n_sticky;
    logic signed [XW-1:0] n_exp;

    logic [MW-1:0]        rnd_frac;
    logic                 rnd_carry, rnd_inx;
    logic signed [XW-1:0] rnd_exp;

    logic [EW+MW:0]       p_res;
    fp_flags_t            p_flags;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (in_valid) state_nx = S_NORM;
            S_NORM:  state_nx = S_ROUND;
            S_ROUND: state_nx = S_PACK;
            S_PACK:  if (out_ready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == S_IDLE);
        out_valid = (state == S_PACK);
        load_in   = (state == S_IDLE) && in_valid;
        do_norm   = (state == S_NORM);
        do_round  = (state == S_ROUND);
    end

    // The product of two hidden-bit mantissas lies in [1,4): the top bit picks a one-place shift.
    always_comb begin
        if (r_prod[PW-1]) begin
            n_frac   = r_prod[PW-2 -: MW];
            n_guard  = r_prod[PW-2-MW];
            n_sticky = |r_prod[PW-3-MW:0];
            n_exp    = r_exp + EXP_ONE;
        end else begin
            n_frac   = r_prod[PW-3 -: MW];
            n_guard  = r_prod[PW-3-MW];
            n_sticky = |r_prod[PW-4-MW:0];
            n_exp    = r_exp;
        end
    end

    fp_round_rne #(.W(MW)) u_round (
        .frac     (r_frac),
        .guard    (r_guard),
        .sticky   (r_sticky),
        .frac_rnd (rnd_frac),
        .carry    (rnd_carry),
        .inexact  (rnd_inx)
    );

    always_comb begin
        rnd_exp = rnd_carry ? (r_exp + EXP_ONE) : r_exp;
        p_res   = {r_sign, rnd_exp[EW-1:0], rnd_frac};
        p_flags = '{ovf: 1'b0, unf: 1'b0, inx: rnd_inx};
        if (r_nan) begin
            p_res   = {1'b0, QNAN_W[EW+MW-1:0]};
            p_flags = '0;
        end else if (r_inf) begin
            p_res   = {r_sign, INF_W[EW+MW-1:0]};
            p_flags = '0;
        end else if (r_zero) begin
            p_res   = {r_sign, {(EW+MW){1'b0}}};
            p_flags = '0;
        end else if (rnd_exp >= EXP_MAX) begin
            p_res   = {r_sign, INF_W[EW+MW-1:0]};
            p_flags = '{ovf: 1'b1, unf: 1'b0, inx: 1'b1};
        end else if (rnd_exp <= EXP_ZERO) begin
            p_res   = {r_sign, {(EW+MW){1'b0}}};
            p_flags = '{ovf: 1'b0, unf: 1'b1, inx: 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sign     <= 1'b0;
            r_zero     <= 1'b0;
            r_inf      <= 1'b0;
            r_nan      <= 1'b0;
            r_exp      <= '0;
            r_prod     <= '0;
            r_frac     <= '0;
            r_guard    <= 1'b0;
            r_sticky   <= 1'b0;
            out_result <= '0;
            flags_q    <= '0;
        end else begin
            if (load_in) begin
                r_sign <= in_sign;
                r_zero <= in_zero;
                r_inf  <= in_inf;
                r_nan  <= in_nan;
                r_exp  <= in_exp_sum;
                r_prod <= in_prod;
            end
            if (do_norm) begin
                r_frac   <= n_frac;
                r_guard  <= n_guard;
                r_sticky <= n_sticky;
                r_exp    <= n_exp;
            end
            if (do_round) begin
                r_frac     <= rnd_frac;
                r_exp      <= rnd_exp;
                out_result <= p_res;
                flags_q    <= p_flags;
            end
        end
    end

    always_comb begin
        out_ovf = flags_q.ovf;
        out_unf = flags_q.unf;
        out_inx = flags_q.inx;
    end

endmodule

// File: doc/fp_mul_norm_round.md
Name: fp_mul_norm_round

Overview:
Downstream stage of the mantissa multiplier in the FP multiply path. Takes the raw 2*(MW+1)-bit unsigned mantissa product, the pre-normalisation exponent, the sign and special-case flags. Normalises the product, rounds to nearest-even and packs an IEEE-754 result. The result is handed to the ALU writeback over a valid/ready handshake.

Parameters:
MW, 23, stored mantissa width (fraction bits, hidden bit excluded)
EW, 8, exponent width
PW, 2*(MW+1), product width (derived, not overridable)

Ports:
clk  input  1  clock
rstn  input  1  asynchronous active-low reset
in_valid  input  1  operands/product valid
in_ready  output  1  stage can accept (high only in S_IDLE)
in_sign  input  1  result sign (sa XOR sb)
in_exp_sum  input  EW+2  signed ea+eb-BIAS, pre-normalisation biased exponent
in_prod  input  PW  unsigned product of hidden-bit mantissas
in_zero  input  1  either operand zero
in_inf  input  1  either operand infinity (and neither zero)
in_nan  input  1  NaN operand or 0*inf
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_result  output  1+EW+MW  {sign, exponent, fraction}
out_ovf  output  1  overflow flag
out_unf  output  1  underflow flag (flush-to-zero)
out_inx  output  1  inexact flag

Behaviour:
- Reset is asynchronous and active-low on rstn; clocked on clk.
- Reset state:
  - state = S_IDLE, so in_ready = 1.
  - out_valid = 0.
  - out_result = 0; out_ovf, out_unf, out_inx = 0.
  - All internal registers = 0.
- Reset mid-operation discards the in-flight operation with no output.
- FSM states: S_IDLE -> S_NORM -> S_ROUND -> S_PACK -> S_IDLE.
- S_IDLE:
  - in_ready = 1.
  - On in_valid, register all inputs and go to S_NORM.
- S_NORM (one cycle):
  - If in_prod[PW-1] = 1: frac = prod[PW-2 -: MW], guard = prod[PW-2-MW], sticky = OR(prod[PW-3-MW:0]), exp = exp_sum+1.
  - Else: frac = prod[PW-3 -: MW], guard = prod[PW-3-MW], sticky = OR(prod[PW-4-MW:0]), exp = exp_sum.
  - prod[PW-1:PW-2] = 00 is legal only with a special flag set; otherwise the result is don't-care. Denormals are unsupported.
- S_ROUND (one cycle), round-to-nearest-even:
  - round_up = guard & (sticky | frac[0]).
  - frac = frac + round_up.
  - On carry-out: frac = 0, exp = exp+1.
  - inx = guard | sticky.
- S_PACK:
  - out_valid = 1. out_result and flags are stable until out_ready.
  - On out_valid & out_ready, go to S_IDLE next cycle.
  - Outputs hold their values after the handshake, but out_valid drops.
- Pack priority (first match wins):
  - nan: 0x7FC00000-style quiet NaN {0, all-ones exp, MSB fraction 1}, flags 0.
  - inf: {sign, all-ones, 0}, flags 0.
  - zero: {sign, 0, 0}, flags 0.
  - exp >= 2^EW-1: {sign, all-ones, 0}, ovf = 1, inx = 1.
  - exp <= 0: {sign, 0, 0}, unf = 1, inx = 1.
  - Otherwise: {sign, exp[EW-1:0], frac}, inx as computed.
- Exponent arithmetic is signed EW+2 bits throughout and never wraps.
- Latency: accept at cycle T gives out_valid at T+3. Minimum initiation interval is 4 cycles.
- Backpressure: while out_ready = 0, remain in S_PACK with in_ready = 0. No input is accepted or lost.

Decomposition:
- Shared package fp_pkg holds:
  - MW, EW, BIAS constants.
  - State enum fsm_state_t (S_IDLE, S_NORM, S_ROUND, S_PACK).
  - Packed struct fp_flags_t {ovf, unf, inx}.
  - Canonical QNAN/INF constant functions.
- One combinational sub-module, fp_round_rne:
  - Inputs: frac, guard, sticky.
  - Outputs: rounded frac, carry, inexact.
  - Reused later by the add/sub path.

Test Plan:
- 1.0*1.0: in_prod = 0x400000000000, exp_sum = 127, sign 0 -> out_result = 0x3F800000, flags 0, out_valid exactly 3 cycles after accept.
- 1.5*1.5: in_prod = 0x900000000000, exp_sum = 127 -> 0x40100000, inx = 0.
- RNE ties:
  - in_prod = 0x400000400000 (guard only, lsb 0) -> 0x3F800000, inx = 1.
  - in_prod = 0x400000C00000 (lsb 1, guard 1) -> 0x3F800002, inx = 1.
- Round carry: in_prod = 0x7FFFFFC00000, exp_sum = 127 -> 0x40000000, inx = 1.
- Exponent limits:
  - exp_sum = 254 with in_prod = 0x800000000000 -> 0x7F800000, ovf = 1.
  - exp_sum = 0 with in_prod = 0x400000000000, sign 1 -> 0x80000000, unf = 1.
- Specials and handshake:
  - in_nan = 1 -> 0x7FC00000.
  - in_zero = 1, sign 1 -> 0x80000000.
  - Hold out_ready = 0 for 5 cycles -> out_valid, out_result stable, in_ready = 0.
  - Assert rstn = 0 in S_ROUND -> out_valid = 0, in_ready = 1, out_result = 0.
